iter_divider: RTL and testbench

Parametrised multi-cycle integer divider for the execute stage; successor to the fixed 32-bit divider. Supports signed and unsigned operation, configurable width and bits-per-cycle, and early termination from the dividend leading-zero count. Handles divide-by-zero and overflow cases with deterministic results. Uses valid/ready handshakes on both sides and a synchronous annul to flush on pipeline kill.

---
 rtl/div_pkg.sv | 35 +++
 rtl/lzc_param.sv | 28 ++
 rtl/iter_divider.sv | 172 +++++++++++++++++
 tb/tb_iter_divider.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider.
// Purpose: FSM state encoding, result packing and the divide-by-zero quotient constant.
// Ports: none (package).
package div_pkg;

  // Divider control states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Widest operand the packing helper handles; instantiations stay at or below it.
  localparam int MAX_WIDTH = 64;

  // Quotient returned for a zero divisor; users take the low WIDTH bits.
  localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUO = '1;

  // Packs {remainder, quotient} with the remainder in the upper half of a
  // 2*width result. Operands are passed zero-extended to MAX_WIDTH.
  function automatic logic [2*MAX_WIDTH-1:0] pack_result(
    input logic [MAX_WIDTH-1:0] rem,
    input logic [MAX_WIDTH-1:0] quo,
    input int                   width
  );
    logic [2*MAX_WIDTH-1:0] r_ext;
    logic [2*MAX_WIDTH-1:0] q_ext;
    r_ext = {{MAX_WIDTH{1'b0}}, rem};
    q_ext = {{MAX_WIDTH{1'b0}}, quo};
    return (r_ext << width) | q_ext;
  endfunction

endpackage

// File: rtl/lzc_param.sv
// Purpose: parametrised leading-zero counter; all-zero input returns WIDTH.
// Latency: purely combinational.
// Backpressure: none, no handshake.
// Ports: value (WIDTH bits in), count ($clog2(WIDTH)+1 bits out).
module lzc_param #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         value,
  output logic [$clog2(WIDTH):0]   count
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic found;

  // Scan from the MSB; the first set bit fixes the count.
  always_comb begin
    count = CW'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = CW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iter_divider.sv
// Purpose: multi-cycle signed/unsigned integer divider with leading-zero early exit.
// Latency: 1 edge for special cases, 2 for a zero dividend, else N+2 (worst WIDTH/UNROLL+2).
// Backpressure: single outstanding op; result held in DONE until out_ready, in_ready low while busy.
// Ports: clk/rst (async, active-high); in_valid/in_ready/signed_op/dividend/divisor request side;
//        annul synchronous flush; out_valid/out_ready/result {rem,quo}/div_zero response side; busy.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               annul,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero,
  output logic               busy
);

  localparam int CW    = $clog2(WIDTH) + 1;
  localparam int LOG_U = $clog2(UNROLL);
  // Clears the low bits of the zero count so skipped bits come in whole UNROLL groups.
  localparam logic [CW-1:0]    SKIP_MASK = ~CW'(UNROLL - 1);
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] QUO_ONES  = DIV_ZERO_QUO[WIDTH-1:0];

  state_t state, state_nxt;

  logic             sop, qneg, rneg;
  logic [WIDTH-1:0] a_q, b_q, b_abs;
  logic [WIDTH-1:0] rem;    // partial remainder
  logic [WIDTH-1:0] shreg;  // dividend bits leave the top, quotient bits enter the bottom
  logic [CW-1:0]    cnt;

  logic             accept;
  logic [WIDTH-1:0] a_abs, b_abs_c;
  logic [CW-1:0]    lz, skip, n_init;
  logic             is_dz, is_ovf;

  function automatic logic [2*WIDTH-1:0] pack(input logic [WIDTH-1:0] r,
                                              input logic [WIDTH-1:0] q);
    logic [2*MAX_WIDTH-1:0] t;
    t = pack_result(MAX_WIDTH'(r), MAX_WIDTH'(q), WIDTH);
    return t[2*WIDTH-1:0];
  endfunction

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state == IDLE) && !annul;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Operand preparation, evaluated from the latched copies during PREP.
  assign a_abs   = (sop && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_abs_c = (sop && b_q[WIDTH-1]) ? -b_q : b_q;
  assign is_dz   = (b_q == '0);
  assign is_ovf  = sop && (a_q == MIN_NEG) && (b_q == '1);

  lzc_param #(.WIDTH(WIDTH)) u_lzc (
    .value (a_abs),
    .count (lz)
  );

  assign skip   = lz & SKIP_MASK;
  assign n_init = (CW'(WIDTH) - skip) >> LOG_U;

  // UNROLL restoring steps. The remainder stays below |B|, so after the shift
  // it fits in WIDTH+1 bits and the top bit of the difference is the borrow.
  logic [WIDTH:0]   r_w, diff;
  logic [WIDTH-1:0] s_w, rem_step, shreg_step;

  always_comb begin
    r_w  = {1'b0, rem};
    s_w  = shreg;
    diff = '0;
    for (int k = 0; k < UNROLL; k++) begin
      r_w  = {r_w[WIDTH-1:0], s_w[WIDTH-1]};
      s_w  = {s_w[WIDTH-2:0], 1'b0};
      diff = r_w - {1'b0, b_abs};
      if (!diff[WIDTH]) begin
        r_w    = diff;
        s_w[0] = 1'b1;
      end
    end
    rem_step   = r_w[WIDTH-1:0];
    shreg_step = s_w;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state; annul wins over every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = PREP;
      PREP: begin
        if (is_dz || is_ovf)     state_nxt = DONE;
        else if (n_init == '0)   state_nxt = FIX;
        else                     state_nxt = ITER;
      end
      ITER: if (cnt == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (annul) state_nxt = IDLE;
  end

  // Datapath. Under annul nothing but div_zero moves, so result stays stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sop      <= 1'b0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      b_abs    <= '0;
      rem      <= '0;
      shreg    <= '0;
      cnt      <= '0;
      result   <= '0;
      div_zero <= 1'b0;
    end else if (annul) begin
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sop      <= signed_op;
            a_q      <= dividend;
            b_q      <= divisor;
            div_zero <= 1'b0;
          end
        end
        PREP: begin
          qneg  <= sop & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rneg  <= sop & a_q[WIDTH-1];
          b_abs <= b_abs_c;
          rem   <= '0;
          shreg <= a_abs << skip;
          cnt   <= n_init;
          if (is_dz) begin
            result   <= pack(a_q, QUO_ONES);
            div_zero <= 1'b1;
          end else if (is_ovf) begin
            result   <= pack('0, a_q);
          end
        end
        ITER: begin
          rem   <= rem_step;
          shreg <= shreg_step;
          cnt   <= cnt - CW'(1);
        end
        FIX: begin
          result <= pack(rneg ? -rem : rem, qneg ? -shreg : shreg);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
module tb_iter_divider;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, signed_op, annul;
  logic [W-1:0]  dividend, divisor;
  logic [1:0]    rdy, ir, ov, dz, bz;
  logic [2*W-1:0] res [2];

  int checks = 0;
  int errors = 0;

  iter_divider #(.WIDTH(W), .UNROLL(1)) u_div1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .annul(annul), .out_valid(ov[0]),
    .out_ready(rdy[0]), .result(res[0]), .div_zero(dz[0]), .busy(bz[0]));

  iter_divider #(.WIDTH(W), .UNROLL(4)) u_div4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .annul(annul), .out_valid(ov[1]),
    .out_ready(rdy[1]), .result(res[1]), .div_zero(dz[1]), .busy(bz[1]));

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: returns {div_zero, remainder, quotient}.
  function automatic logic [64:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
    if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'd0, a};
    if (sgn) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, r, q};
  endfunction

  // Edges from accept to out_valid.
  function automatic int ref_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int u);
    logic [31:0] mag;
    int lz, skip;
    if (b == 32'd0 || (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
    mag = (sgn && a[31]) ? -a : a;
    if (mag == 32'd0) return 2;
    lz = 0;
    while (!mag[31 - lz]) lz++;
    skip = (lz / u) * u;
    return (32 - skip) / u + 2;
  endfunction

  // Transaction-level model of each instance.
  logic        m_busy [2];
  logic        m_valid[2];
  int          m_left [2];
  logic [63:0] m_res  [2];
  logic [63:0] p_res  [2];
  logic        m_dz   [2];
  logic        p_dz   [2];

  always @(posedge clk or posedge rst) begin
    logic [64:0] r;
    r = ref_div(signed_op, dividend, divisor);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] <= 1'b0; m_valid[i] <= 1'b0; m_left[i] <= 0;
        m_res[i] <= '0; p_res[i] <= '0; m_dz[i] <= 1'b0; p_dz[i] <= 1'b0;
      end else if (annul) begin
        m_busy[i] <= 1'b0; m_valid[i] <= 1'b0; m_dz[i] <= 1'b0;
      end else if (m_valid[i]) begin
        if (rdy[i]) begin
          m_busy[i] <= 1'b0; m_valid[i] <= 1'b0;
        end
      end else if (m_busy[i]) begin
        if (m_left[i] <= 1) begin
          m_valid[i] <= 1'b1; m_res[i] <= p_res[i]; m_dz[i] <= p_dz[i];
        end
        m_left[i] <= m_left[i] - 1;
      end else if (in_valid) begin
        m_busy[i] <= 1'b1;
        m_left[i] <= ref_lat(signed_op, dividend, divisor, (i == 0) ? 1 : 4);
        p_res[i]  <= r[63:0];
        p_dz[i]   <= r[64];
      end
    end
  end

  // Cycle compare against the model, sampled mid-low-phase.
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("out_valid[%0d]", i), ov[i], m_valid[i]);
      chk($sformatf("busy[%0d]", i), bz[i], m_busy[i]);
      chk($sformatf("in_ready[%0d]", i), ir[i], !m_busy[i] && !annul);
      if (m_valid[i]) begin
        chk($sformatf("result[%0d]", i), res[i], m_res[i]);
        chk($sformatf("div_zero[%0d]", i), dz[i], m_dz[i]);
      end
    end
  end

  int          lat_seen[2];
  logic [63:0] res_seen[2];
  logic [1:0]  dz_seen;

  // Caller sits on a negedge with both instances idle.
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    signed_op = sgn; dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = $urandom; divisor = $urandom; signed_op = 1'($urandom);
  endtask

  task automatic finish_op(input int hold);
    int e;
    logic [1:0] seen;
    e = 0; seen = 2'b00;
    lat_seen[0] = -1; lat_seen[1] = -1;
    while (1) begin
      @(posedge clk);
      @(negedge clk);
      e++;
      for (int i = 0; i < 2; i++) begin
        if (ov[i] && !seen[i]) begin
          seen[i] = 1'b1; lat_seen[i] = e; res_seen[i] = res[i]; dz_seen[i] = dz[i];
        end
        if (seen[i] && (e - lat_seen[i]) >= hold) rdy[i] = 1'b1;
      end
      if (seen == 2'b11 && !m_busy[0] && !m_busy[1]) break;
      if (e > 200) begin
        checks++; errors++;
        $display("FAIL op_timeout: got no completion after %0d edges, required within 200", e);
        rdy = 2'b11;
        break;
      end
    end
  endtask

  task automatic op(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] erem, input logic [31:0] equo,
                    input int lat1, input int lat4, input logic edz, input int hold);
    launch(sgn, a, b);
    finish_op(hold);
    chk({name, " lat u1"}, 72'(lat_seen[0]), 72'(lat1));
    chk({name, " lat u4"}, 72'(lat_seen[1]), 72'(lat4));
    chk({name, " res u1"}, res_seen[0], {erem, equo});
    chk({name, " res u4"}, res_seen[1], {erem, equo});
    chk({name, " dz"}, dz_seen, {edz, edz});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; annul = 1'b0; rdy = 2'b11;
    signed_op = 1'b0; dividend = '0; divisor = '0;

    // Model pinned against hand-computed values.
    chk("model div 100/7", ref_div(1'b1, 32'd100, 32'd7), {1'b0, 32'd2, 32'd14});
    chk("model div -7/2", ref_div(1'b1, 32'hFFFFFFF9, 32'd2), {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
    chk("model lat 100/7 u1", 72'(ref_lat(1'b1, 32'd100, 32'd7, 1)), 72'd9);
    chk("model lat max u4", 72'(ref_lat(1'b0, 32'hFFFFFFFF, 32'h10, 4)), 72'd10);

    repeat (2) @(negedge clk);
    chk("reset out_valid", ov, 2'b00);
    chk("reset busy", bz, 2'b00);
    chk("reset result u1", res[0], 64'd0);
    chk("reset div_zero", dz, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    op("t1 100/7",       1, 32'd100,        32'd7,          32'd2,          32'd14,         9,  4,  0, 0);
    op("t2 -7/2",        1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   5,  3,  0, 0);
    op("t3 max/16",      0, 32'hFFFFFFFF,   32'h10,         32'hF,          32'h0FFFFFFF,   34, 10, 0, 0);
    op("t4 ovf",         1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1,  1,  0, 0);
    op("t4 dz",          0, 32'h1234,       32'd0,          32'h1234,       32'hFFFFFFFF,   1,  1,  1, 0);
    op("dz signed",      1, 32'h1234,       32'd0,          32'h1234,       32'hFFFFFFFF,   1,  1,  1, 0);
    op("-100/7",         1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   32'hFFFFFFF2,   9,  4,  0, 0);
    op("100/-7",         1, 32'd100,        32'hFFFFFFF9,   32'd2,          32'hFFFFFFF2,   9,  4,  0, 0);
    op("uns min/ones",   0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          34, 10, 0, 0);
    op("min/1 signed",   1, 32'h80000000,   32'd1,          32'd0,          32'h80000000,   34, 10, 0, 0);
    op("5/min signed",   1, 32'd5,          32'h80000000,   32'd5,          32'd0,          5,  3,  0, 0);

    // Backpressure: result held five extra cycles in DONE.
    rdy = 2'b00;
    op("hold 100/7",     1, 32'd100,        32'd7,          32'd2,          32'd14,         9,  4,  0, 5);

    // Annul during the third ITER cycle.
    launch(1'b1, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul = 1'b0;
    chk("annul busy", bz, 2'b00);
    chk("annul out_valid", ov, 2'b00);
    chk("annul div_zero", dz, 2'b00);
    op("post-annul -7/2", 1, 32'hFFFFFFF9,  32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   5,  3,  0, 0);

    // Asynchronous reset mid-ITER.
    launch(1'b0, 32'hFFFFFFFF, 32'h10);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst out_valid", ov, 2'b00);
    chk("arst busy", bz, 2'b00);
    chk("arst result u1", res[0], 64'd0);
    chk("arst result u4", res[1], 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op("0/5 signed",     1, 32'd0,          32'd5,          32'd0,          32'd0,          2,  2,  0, 0);
    op("0/0 unsigned",   0, 32'd0,          32'd0,          32'd0,          32'hFFFFFFFF,   1,  1,  1, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
